// File: rtl/xor_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : xor_arbiter_pkg
//  Brief   : Shared types and constants for the round-robin XOR arbiter:
//            FSM state enum, ID-width helper and grant-counter saturation value.
//  Rev     : 1.0  initial release
// ============================================================================
package xor_arbiter_pkg;

    // IDLE: no response held; RESP: response register holds a result
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // Saturation value of the optional grant counter
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    // Width needed to encode a requester index; never less than one bit
    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage : xor_arbiter_pkg
`default_nettype wire

// File: rtl/xor_core.sv
`default_nettype none
// ============================================================================
//  Module  : xor_core
//  Brief   : Combinational XOR reduction of one WIDTH-bit operand.
//  Rev     : 1.0  initial release
// ============================================================================
module xor_core #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] operand,
    output logic             result
);

    assign result = ^operand;

endmodule : xor_core
`default_nettype wire

// File: rtl/xor_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : xor_arbiter
//  Brief   : Round-robin arbiter sharing one XOR-reduction unit among
//            NUM_REQ requesters. One-cycle latency, one registered response
//            slot, back-to-back service while the consumer is ready.
//  Config  : define XOR_ARBITER_STATS_EN to add the 16-bit saturating
//            stat_grants output.
//  Rev     : 1.0  initial release
// ============================================================================
module xor_arbiter
    import xor_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        resp_valid,
    output logic [clog2(NUM_REQ)-1:0]   resp_id,
    output logic                        resp_data,
    input  logic                        resp_ready
`ifdef XOR_ARBITER_STATS_EN
    ,
    output logic [15:0]                 stat_grants
`endif
);

    localparam int ID_W = clog2(NUM_REQ);

    state_t            r_state;
    state_t            w_state_next;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_resp_id;
    logic              r_resp_data;

    logic              w_accept;
    logic              w_found;
    logic [ID_W-1:0]   w_grant_idx;
    logic              w_grant;
    logic [WIDTH-1:0]  w_operand;
    logic              w_xor_out;
    logic [ID_W-1:0]   w_next_ptr;

    // A new operand may be taken when the response slot is empty or being drained
    assign w_accept = (r_state == IDLE) || resp_ready;
    assign w_grant  = reset && w_accept && w_found;

    // Search upward from rr_ptr for the first valid requester, wrapping at NUM_REQ
    always_comb begin
        int          cand;
        logic [ID_W-1:0] cand_idx;
        w_found     = 1'b0;
        w_grant_idx = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(r_rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_W'(cand);
            if (!w_found && req_valid[cand_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = cand_idx;
            end
        end
    end

    // One-hot ready to the granted requester, and operand selection for the XOR unit
    always_comb begin
        req_ready = '0;
        w_operand = '0;
        if (w_grant) begin
            req_ready[w_grant_idx] = 1'b1;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_operand = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    xor_core #(
        .WIDTH (WIDTH)
    ) u_xor_core (
        .operand (w_operand),
        .result  (w_xor_out)
    );

    assign w_next_ptr = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_grant_idx + ID_W'(1));

    // Next-state: on accept, hold a response if something was granted, else go idle
    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = w_found ? RESP : IDLE;
        end
    end

    // State register; reset discards any held response
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Response register and round-robin pointer update on each grant
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_resp_id   <= '0;
            r_resp_data <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_grant) begin
            r_resp_id   <= w_grant_idx;
            r_resp_data <= w_xor_out;
            r_rr_ptr    <= w_next_ptr;
        end
    end

    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;

`ifdef XOR_ARBITER_STATS_EN
    logic [15:0] r_stat_grants;

    // Saturating grant counter
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stat_grants <= '0;
        end else if (w_grant && (r_stat_grants != STAT_MAX)) begin
            r_stat_grants <= r_stat_grants + 16'd1;
        end
    end

    assign stat_grants = r_stat_grants;
`endif

endmodule : xor_arbiter
`default_nettype wire

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..16).
REQ-002 The block SHALL have parameter WIDTH, default 2, giving the operand width in bits reduced by XOR.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset (0 = reset asserted), sampled on the clock rising edge.
REQ-005 Port req_valid  input  NUM_REQ  bit k = requester k holds a valid operand.
REQ-006 Port req_data  input  NUM_REQ*WIDTH  operand k in bits [k*WIDTH +: WIDTH].
REQ-007 Port req_ready  output  NUM_REQ  bit k = operand k accepted this cycle (one-hot or zero).
REQ-008 Port resp_valid  output  1  response holds a result.
REQ-009 Port resp_id  output  clog2(NUM_REQ)  index of the requester that owns the response.
REQ-010 Port resp_data  output  1  XOR reduction of the accepted operand.
REQ-011 Port resp_ready  input  1  consumer accepts the response this cycle.

Function
REQ-012 The block SHALL share a single XOR-reduction unit among all requesters via a round-robin arbiter.
REQ-013 States SHALL be IDLE (no response held) and RESP (response held, resp_valid=1).
REQ-014 Accept condition: (state==IDLE) or (state==RESP and resp_ready==1); req_ready SHALL be 0 when the accept condition is false.
REQ-015 When the accept condition holds and any req_valid is 1, the block SHALL assert req_ready for exactly one requester g: the first valid index found searching upward from rr_ptr, wrapping modulo NUM_REQ.
REQ-016 On a grant, the next cycle SHALL have state=RESP, resp_id=g, resp_data=^operand g, and rr_ptr=(g+1) mod NUM_REQ.
REQ-017 When the accept condition holds in RESP and no req_valid is set, the next state SHALL be IDLE with resp_valid=0.
REQ-018 In RESP without resp_ready, resp_valid, resp_id and resp_data SHALL hold stable; requesters stay unserved.
REQ-019 Latency SHALL be one cycle from grant to resp_valid; back-to-back grants SHALL give one response per cycle while resp_ready=1.
REQ-020 rr_ptr SHALL change only on a grant; wrap from NUM_REQ-1 to 0.
REQ-021 req_ready SHALL be a combinational function of state, rr_ptr, req_valid and resp_ready; responses SHALL be registered.

Reset
REQ-022 With reset=0 at a rising edge: state=IDLE, resp_valid=0, resp_id=0, resp_data=0, rr_ptr=0, and req_ready=0 during that cycle.
REQ-023 Reset asserted while in RESP SHALL discard the held response, and the requester SHALL NOT be re-served.

Configuration
REQ-024 Macro XOR_ARBITER_STATS_EN defined: the block SHALL add output stat_grants (16 bits) counting grants, saturating at 16'hFFFF, cleared by reset.
REQ-025 Macro undefined: the stat_grants port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 Package xor_arbiter_pkg SHALL hold the state enum (IDLE, RESP), the ID-width function clog2(NUM_REQ) and the saturation constant STAT_MAX=16'hFFFF.
REQ-027 The XOR reduction SHALL be a combinational sub-module xor_core (input WIDTH bits, output 1 bit), instantiated once.

Verification
REQ-028 After reset, req_valid=4'b0001, req_data[1:0]=2'b10, resp_ready=1 -> req_ready=4'b0001 that cycle; next cycle resp_valid=1, resp_id=0, resp_data=1.
REQ-029 req_valid=4'b1111, data for all requesters = {2'b11,2'b01,2'b10,2'b00}, resp_ready=1 constantly -> grants 0,1,2,3,0 on consecutive cycles; resp_data sequence 0,1,1,0.
REQ-030 Grant requester 2, hold resp_ready=0 for 5 cycles with req_valid=4'b1111 -> resp_id=2 stable, req_ready=0 throughout; on resp_ready=1, requester 3 is granted.
REQ-031 rr_ptr=3 (after granting requester 2), req_valid=4'b0011 -> requester 0 is granted (wrap), then requester 1.
REQ-032 Assert reset=0 in RESP -> next cycle resp_valid=0, resp_id=0, rr_ptr=0; with STATS_EN defined, stat_grants=0.
REQ-033 With STATS_EN defined, 65540 grants -> stat_grants=16'hFFFF, holding at that value.
